// File: rtl/adc_pwm_arb_pkg.sv
// rtl/adc_pwm_arb_pkg.sv - shared widths, master indices and lock-owner encoding
package adc_pwm_arb_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_BE_W   = 4;

  localparam int M0 = 0;
  localparam int M1 = 1;

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_M0   = 2'd1,
    LOCK_M1   = 2'd2
  } lock_owner_e;

endpackage

// File: rtl/adc_pwm_rr_arb2.sv
// rtl/adc_pwm_rr_arb2.sv - two-way round-robin arbiter with capped lock
module adc_pwm_rr_arb2
  import adc_pwm_arb_pkg::*;
#(
  parameter int LOCK_MAX = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] grant
);

  localparam logic [7:0] CNT_MAX = 8'(LOCK_MAX);

  logic        last_grant, last_grant_nxt;
  lock_owner_e lock_owner, lock_owner_nxt;
  logic [7:0]  lock_cnt, lock_cnt_nxt;
  logic        hold0, hold1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      lock_owner <= LOCK_NONE;
      lock_cnt   <= '0;
    end else begin
      last_grant <= last_grant_nxt;
      lock_owner <= lock_owner_nxt;
      lock_cnt   <= lock_cnt_nxt;
    end
  end

  // A capped lock falls through to plain round-robin, which favours the other master.
  always_comb begin
    grant = 2'b00;
    hold0 = (lock_owner == LOCK_M0) && req[M0] && (lock_cnt < CNT_MAX);
    hold1 = (lock_owner == LOCK_M1) && req[M1] && (lock_cnt < CNT_MAX);
    if (!reset_n)
      grant = 2'b00;
    else if (hold0)
      grant = 2'b01;
    else if (hold1)
      grant = 2'b10;
    else if (&req)
      grant = last_grant ? 2'b01 : 2'b10;
    else
      grant = req;
  end

  always_comb begin
    last_grant_nxt = last_grant;
    lock_owner_nxt = LOCK_NONE;
    lock_cnt_nxt   = '0;
    if (grant[M0]) begin
      last_grant_nxt = 1'b0;
      if (lock[M0]) begin
        lock_owner_nxt = LOCK_M0;
        lock_cnt_nxt   = (lock_owner != LOCK_M0) ? 8'd1 :
                         (lock_cnt >= CNT_MAX)   ? CNT_MAX : lock_cnt + 8'd1;
      end
    end else if (grant[M1]) begin
      last_grant_nxt = 1'b1;
      if (lock[M1]) begin
        lock_owner_nxt = LOCK_M1;
        lock_cnt_nxt   = (lock_owner != LOCK_M1) ? 8'd1 :
                         (lock_cnt >= CNT_MAX)   ? CNT_MAX : lock_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/adc_pwm_mem_arbiter.sv
// rtl/adc_pwm_mem_arbiter.sv - two-master Avalon-MM arbiter for the 1024x32 on-chip memory
module adc_pwm_mem_arbiter
  import adc_pwm_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int BE_W     = DEF_BE_W,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic              m0_lock,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic              m1_lock,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic [1:0] req, lock, grant;
  logic       any_grant, win_sel, win_read, win_write;
  logic       rd_pend, rd_owner, rdv, rdv_owner;

  assign req  = {m1_read | m1_write, m0_read | m0_write};
  assign lock = {m1_lock, m0_lock};

  adc_pwm_rr_arb2 #(.LOCK_MAX(LOCK_MAX)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .lock    (lock),
    .grant   (grant)
  );

  assign any_grant      = |grant;
  assign win_sel        = grant[M1];
  assign win_read       = win_sel ? m1_read  : m0_read;
  assign win_write      = win_sel ? m1_write : m0_write;
  assign m0_waitrequest = ~grant[M0];
  assign m1_waitrequest = ~grant[M1];

  // Read with write asserted is a write; it never occupies the read-return pipe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_address    <= '0;
      mem_byteenable <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
      rd_pend        <= 1'b0;
      rd_owner       <= 1'b0;
      rdv            <= 1'b0;
      rdv_owner      <= 1'b0;
    end else begin
      mem_chipselect <= any_grant;
      mem_write      <= any_grant & win_write;
      rd_pend        <= any_grant & win_read & ~win_write;
      rdv            <= rd_pend;
      rdv_owner      <= rd_owner;
      if (any_grant) begin
        mem_address    <= win_sel ? m1_address    : m0_address;
        mem_byteenable <= win_sel ? m1_byteenable : m0_byteenable;
        mem_writedata  <= win_sel ? m1_writedata  : m0_writedata;
        rd_owner       <= win_sel;
      end
    end
  end

  assign mem_clken        = 1'b1;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rdv & ~rdv_owner;
  assign m1_readdatavalid = rdv & rdv_owner;

endmodule

// File: doc/adc_pwm_mem_arbiter.md
Name: adc_pwm_mem_arbiter

Overview:
- Two-master Avalon-MM arbiter in front of the single-port 1024x32 on-chip memory (byte enables, clock enable, unregistered output).
- Shares that memory between the Nios data master (m0) and the ADC sample/PWM table engine (m1).
- Uses round-robin with optional lock, a capped lock length, a registered command stage, and 2-cycle read latency.

Parameters:
ADDR_W, 10, word address width (1024 words)
DATA_W, 32, data width
BE_W, 4, byte-enable width (DATA_W/8)
LOCK_MAX, 16, max consecutive locked grants before the other master is forced in; 1..255

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m0_address / m1_address  in  ADDR_W  word address
m0_byteenable / m1_byteenable  in  BE_W  byte enables
m0_read / m1_read  in  1  read request
m0_write / m1_write  in  1  write request
m0_writedata / m1_writedata  in  DATA_W  write data
m0_lock / m1_lock  in  1  hold grant across consecutive transfers
m0_waitrequest / m1_waitrequest  out  1  high = request not accepted this cycle
m0_readdata / m1_readdata  out  DATA_W  read data (shared, = mem_readdata)
m0_readdatavalid / m1_readdatavalid  out  1  read data valid
mem_address  out  ADDR_W  registered memory address
mem_byteenable  out  BE_W  registered byte enables
mem_chipselect  out  1  registered chip select
mem_write  out  1  registered write
mem_writedata  out  DATA_W  registered write data
mem_clken  out  1  memory clock enable, tied 1
mem_readdata  in  DATA_W  memory read data, valid 1 cycle after address is presented

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous, active-low.
- Reset values:
  - all mem_* registers are 0.
  - readdatavalid outputs are 0.
  - last_grant = m1, so m0 wins the first contention.
  - lock_owner = none; lock_cnt = 0.
- Request definition: req_i = mi_read | mi_write. If read and write are both high, it is treated as a write and no readdatavalid is issued.
- Grant (combinational each cycle, at most one master):
  - Lock held: if lock_owner = i, req_i = 1, and lock_cnt < LOCK_MAX, grant i.
  - Contention: else if both request, grant the master not equal to last_grant.
  - Single requester: else grant whichever one requests.
- Waitrequest: mi_waitrequest = ~(grant_i). It is high for a non-requesting master and high during reset.
- On a grant to i:
  - last_grant <= i.
  - If mi_lock = 1: lock_owner <= i and lock_cnt <= lock_cnt + 1 (saturating). Otherwise lock_owner <= none and lock_cnt <= 0.
- Lock cap: when lock_cnt = LOCK_MAX and the other master requests, the other master is granted; lock_owner clears and lock_cnt <= 0. If the other master is idle, the owner keeps its grant, and lock_cnt holds at LOCK_MAX until the lock is released.
- Lock release: lock_owner clears when the owner is not granted, or drops mi_lock on its granted transfer.
- Stage 1 (cycle N+1 after accept in N):
  - mem_chipselect <= any grant.
  - mem_write <= granted write.
  - address, byteenable and writedata are captured from the winner.
  - rd_pend <= granted read; rd_owner <= i.
  - With no grant: chipselect = 0 and write = 0; the other mem_* registers hold.
- Stage 2:
  - rdv <= rd_pend; rdv_owner <= rd_owner.
  - mi_readdatavalid = rdv & (rdv_owner == i).
  - Read data appears in cycle N+2 (2-cycle latency, one read per cycle, fully pipelined).
- Writes commit at the clock edge ending cycle N+1.
- Read-after-write hazard: a write accepted in N and a read of the same address accepted in N+1 (either master) return the new data. Ordering is strictly acceptance order.
- Reset asserted mid-operation: the pipeline clears asynchronously, in-flight reads produce no readdatavalid, and partly issued writes may or may not land.
- No buffering: a master must hold its request stable while waitrequest = 1 (Avalon rule). The arbiter never drops an accepted transfer.

Decomposition:
- Package adc_pwm_arb_pkg holds:
  - ADDR_W, DATA_W and BE_W defaults.
  - master index constants M0 = 0 and M1 = 1.
  - the lock_owner encoding {NONE, M0, M1}.
- One sub-module: adc_pwm_rr_arb2. It is the two-way round-robin and lock arbiter: inputs req[1:0] and lock[1:0]; outputs grant[1:0]; it owns last_grant, lock_owner and lock_cnt.
- The top level holds the command stage, the readdatavalid pipeline and the muxing.

Test Plan:
- Reset release, m0 read addr 0x005 (memory holds 0xDEADBEEF): accepted in the first cycle; m0_readdatavalid = 1 with readdata 0xDEADBEEF exactly 2 cycles later; m1_readdatavalid stays 0.
- m0 and m1 request continuously from reset: grants alternate m0, m1, m0, m1; each waitrequest is low every other cycle.
- m1 write 0x3FF = 0x12345678 with byteenable 0x3, then m0 read 0x3FF the next cycle (memory was 0xFFFFFFFF): m0 reads 0xFFFF5678.
- m0 holds lock with continuous writes while m1 requests, LOCK_MAX = 4: m0 gets 4 grants, m1 gets 1, then m0 resumes its locked run.
- m0 read and write asserted together at addr 0x010, data 0xA5A5A5A5: mem_write = 1, memory updated, no readdatavalid.
- reset_n pulsed low 1 cycle after a read is accepted: no readdatavalid for that read; after release, mem_chipselect = 0 and arbitration restarts with m0 priority.
